pio_loader: RTL and testbench

PIO_LOADER -- requirements
Module: pio_loader

---
 rtl/pio_loader.sv | 201 ++++++++++++++++++++
 tb/tb_pio_loader.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/pio_loader.sv
// pio_loader: boot-time loader for a PIO block, followed by a push path.
//   - Streams PROG_LEN instructions from the program ROM as writes (action 1).
//   - Streams NUM_SM x CLEN configuration entries from the config ROM.
//   - Enters RUN, where it forwards pushes to per-machine TX FIFOs (action 4).
// Ports:
//   clk, n_reset             : clock, asynchronous active-low reset
//   prog_addr / prog_data    : program ROM, read data one cycle after address
//   conf_addr / conf_data    : config ROM {sm, entry}, one-cycle read latency
//   action, din, index,
//   mindex                   : registered PIO command outputs
//   tx_full                  : per-machine TX FIFO full flags
//   reload                   : restart the full load sequence (honoured in RUN only)
//   loaded                   : high while in RUN
//   push_valid/machine/data,
//   push_ready               : push handshake (push_ready is combinational)
module pio_loader #(
    parameter int unsigned PROG_LEN = 32,
    parameter int unsigned NUM_SM   = 2,
    parameter int unsigned CLEN     = 10
) (
    input  logic        clk,
    input  logic        n_reset,
    output logic [4:0]  prog_addr,
    input  logic [15:0] prog_data,
    output logic [6:0]  conf_addr,
    input  logic [35:0] conf_data,
    output logic [3:0]  action,
    output logic [31:0] din,
    output logic [4:0]  index,
    output logic [1:0]  mindex,
    input  logic [3:0]  tx_full,
    input  logic        reload,
    output logic        loaded,
    input  logic        push_valid,
    input  logic [1:0]  push_machine,
    input  logic [31:0] push_data,
    output logic        push_ready
);

    localparam int unsigned CNT_W      = 8;
    localparam int unsigned CONF_TOTAL = NUM_SM * CLEN;
    // Two extra cycles after the last fetch: retire it, then one idle cycle.
    localparam int unsigned DRAIN_END  = CONF_TOTAL + 2;

    typedef enum logic [1:0] {
        LOAD_PROG = 2'd0,
        LOAD_CONF = 2'd1,
        RUN       = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [4:0]         prog_addr_q, prog_addr_d;
    logic [1:0]         sm_q, sm_d;
    logic [4:0]         ent_q, ent_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               pend_prog_q, pend_prog_d;
    logic [4:0]         pend_idx_q, pend_idx_d;
    logic               pend_conf_q, pend_conf_d;
    logic [1:0]         pend_sm_q, pend_sm_d;
    logic [3:0]         action_q, action_d;
    logic [31:0]        din_q, din_d;
    logic [4:0]         index_q, index_d;
    logic [1:0]         mindex_q, mindex_d;
    logic               loaded_q, loaded_d;
    logic               blk_q, blk_d;
    logic [1:0]         blk_m_q, blk_m_d;

    logic               block_c;
    logic               push_fire_c;

    // tx_full lags a push by one cycle, so the just-pushed machine is held off.
    assign block_c     = blk_q && (blk_m_q == push_machine);
    assign push_ready  = loaded_q & ~tx_full[push_machine] & ~reload & ~block_c;
    assign push_fire_c = push_valid & push_ready;

    assign prog_addr = prog_addr_q;
    assign conf_addr = {sm_q, ent_q};
    assign action    = action_q;
    assign din       = din_q;
    assign index     = index_q;
    assign mindex    = mindex_q;
    assign loaded    = loaded_q;

    // State and datapath registers
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q     <= LOAD_PROG;
            prog_addr_q <= '0;
            sm_q        <= '0;
            ent_q       <= '0;
            cnt_q       <= '0;
            pend_prog_q <= 1'b0;
            pend_idx_q  <= '0;
            pend_conf_q <= 1'b0;
            pend_sm_q   <= '0;
            action_q    <= '0;
            din_q       <= '0;
            index_q     <= '0;
            mindex_q    <= '0;
            loaded_q    <= 1'b0;
            blk_q       <= 1'b0;
            blk_m_q     <= '0;
        end else begin
            state_q     <= state_d;
            prog_addr_q <= prog_addr_d;
            sm_q        <= sm_d;
            ent_q       <= ent_d;
            cnt_q       <= cnt_d;
            pend_prog_q <= pend_prog_d;
            pend_idx_q  <= pend_idx_d;
            pend_conf_q <= pend_conf_d;
            pend_sm_q   <= pend_sm_d;
            action_q    <= action_d;
            din_q       <= din_d;
            index_q     <= index_d;
            mindex_q    <= mindex_d;
            loaded_q    <= loaded_d;
            blk_q       <= blk_d;
            blk_m_q     <= blk_m_d;
        end
    end

    // Next-state and output logic
    always_comb begin
        state_d     = state_q;
        prog_addr_d = prog_addr_q;
        sm_d        = sm_q;
        ent_d       = ent_q;
        cnt_d       = cnt_q;
        pend_prog_d = 1'b0;
        pend_idx_d  = pend_idx_q;
        pend_conf_d = 1'b0;
        pend_sm_d   = pend_sm_q;
        action_d    = 4'd0;
        din_d       = din_q;
        index_d     = index_q;
        mindex_d    = mindex_q;
        blk_d       = 1'b0;
        blk_m_d     = blk_m_q;

        // Retire the ROM reads issued in the previous cycle
        if (pend_prog_q) begin
            action_d = 4'd1;
            index_d  = pend_idx_q;
            din_d    = {16'h0000, prog_data};
        end
        if (pend_conf_q) begin
            action_d = conf_data[35:32];
            din_d    = conf_data[31:0];
            mindex_d = pend_sm_q;
        end

        unique case (state_q)
            LOAD_PROG: begin
                pend_prog_d = 1'b1;
                pend_idx_d  = prog_addr_q;
                if (prog_addr_q == 5'(PROG_LEN - 1)) begin
                    prog_addr_d = '0;
                    sm_d        = '0;
                    ent_d       = '0;
                    cnt_d       = '0;
                    state_d     = LOAD_CONF;
                end else begin
                    prog_addr_d = prog_addr_q + 5'd1;
                end
            end
            LOAD_CONF: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q < CNT_W'(CONF_TOTAL)) begin
                    pend_conf_d = 1'b1;
                    pend_sm_d   = sm_q;
                    if (ent_q == 5'(CLEN - 1)) begin
                        ent_d = '0;
                        sm_d  = sm_q + 2'd1;
                    end else begin
                        ent_d = ent_q + 5'd1;
                    end
                end
                if (cnt_q == CNT_W'(DRAIN_END)) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (reload) begin
                    state_d     = LOAD_PROG;
                    prog_addr_d = '0;
                end else if (push_fire_c) begin
                    action_d = 4'd4;
                    mindex_d = push_machine;
                    din_d    = push_data;
                    blk_d    = 1'b1;
                    blk_m_d  = push_machine;
                end
            end
            default: state_d = LOAD_PROG;
        endcase

        loaded_d = (state_d == RUN);
    end

endmodule

// File: tb/tb_pio_loader.sv
// Self-checking bench for pio_loader: load sequence, push table, random pushes,
// reload and mid-load reset.
module tb_pio_loader;

    localparam int unsigned PROG_LEN = 32;
    localparam int unsigned NUM_SM   = 2;
    localparam int unsigned CLEN     = 10;

    logic        clk;
    logic        n_reset;
    logic [4:0]  prog_addr;
    logic [15:0] prog_data;
    logic [6:0]  conf_addr;
    logic [35:0] conf_data;
    logic [3:0]  action;
    logic [31:0] din;
    logic [4:0]  index;
    logic [1:0]  mindex;
    logic [3:0]  tx_full;
    logic        reload;
    logic        loaded;
    logic        push_valid;
    logic [1:0]  push_machine;
    logic [31:0] push_data;
    logic        push_ready;

    pio_loader #(.PROG_LEN(PROG_LEN), .NUM_SM(NUM_SM), .CLEN(CLEN)) dut (
        .clk(clk), .n_reset(n_reset),
        .prog_addr(prog_addr), .prog_data(prog_data),
        .conf_addr(conf_addr), .conf_data(conf_data),
        .action(action), .din(din), .index(index), .mindex(mindex),
        .tx_full(tx_full), .reload(reload), .loaded(loaded),
        .push_valid(push_valid), .push_machine(push_machine),
        .push_data(push_data), .push_ready(push_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Synchronous ROMs with one-cycle read latency
    logic [15:0] prog_rom [32];
    logic [35:0] conf_rom [128];
    always @(posedge clk) begin
        prog_data <= prog_rom[prog_addr];
        conf_data <= conf_rom[conf_addr];
    end

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: last values the PIO side should observe
    logic [3:0]  m_action;
    logic [31:0] m_din;
    logic [4:0]  m_index;
    logic [1:0]  m_mindex;
    logic        m_loaded;
    logic        m_blk;
    logic [1:0]  m_blk_m;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_action = '0; m_din = '0; m_index = '0; m_mindex = '0;
        m_loaded = 1'b0; m_blk = 1'b0; m_blk_m = '0;
    endtask

    task automatic chk_outs(input string nm);
        chk(nm, 64'({action, din, index, mindex, loaded}),
                64'({m_action, m_din, m_index, m_mindex, m_loaded}));
    endtask

    // Full load sequence from the first edge after reset release or reload
    task automatic check_load();
        int last_k;
        last_k = PROG_LEN + NUM_SM * CLEN + 3;
        for (int k = 1; k <= last_k; k++) begin
            push_valid   = 1'($urandom);
            push_machine = 2'($urandom);
            push_data    = $urandom;
            tx_full      = 4'($urandom);
            reload       = 1'($urandom);
            #1;
            chk("load_ready", 64'(push_ready), 64'(0));
            @(posedge clk);
            #1;
            m_action = 4'd0;
            if (k >= 2 && k <= int'(PROG_LEN) + 1) begin
                m_action = 4'd1;
                m_index  = 5'(k - 2);
                m_din    = {16'h0000, prog_rom[k - 2]};
            end else if (k >= int'(PROG_LEN) + 2 && k < int'(PROG_LEN) + 2 + int'(NUM_SM * CLEN)) begin
                int e, sm, c;
                logic [35:0] w;
                e  = k - int'(PROG_LEN) - 2;
                sm = e / int'(CLEN);
                c  = e % int'(CLEN);
                w  = conf_rom[sm * 32 + c];
                m_action = w[35:32];
                m_din    = w[31:0];
                m_mindex = 2'(sm);
            end
            m_loaded = (k == last_k);
            m_blk    = 1'b0;
            chk_outs("load_seq");
        end
        reload     = 1'b0;
        push_valid = 1'b0;
        tx_full    = 4'h0;
    endtask

    // One RUN cycle: check push_ready before the edge, outputs after it
    task automatic run_cycle(input logic pv, input logic [1:0] pm, input logic [31:0] pd,
                             input logic [3:0] tf, input logic rl, output logic rdy_seen);
        logic exp_ready;
        push_valid = pv; push_machine = pm; push_data = pd; tx_full = tf; reload = rl;
        #1;
        exp_ready = m_loaded && !tf[pm] && !rl && !(m_blk && m_blk_m == pm);
        rdy_seen  = push_ready;
        chk("run_ready", 64'(push_ready), 64'(exp_ready));
        @(posedge clk);
        #1;
        if (rl && m_loaded) begin
            m_action = 4'd0; m_loaded = 1'b0; m_blk = 1'b0;
        end else if (pv && exp_ready) begin
            m_action = 4'd4; m_mindex = pm; m_din = pd; m_blk = 1'b1; m_blk_m = pm;
        end else begin
            m_action = 4'd0; m_blk = 1'b0;
        end
        chk_outs("run_out");
    endtask

    typedef struct {
        logic        pv;
        logic [1:0]  pm;
        logic [31:0] pd;
        logic [3:0]  tf;
        logic        exp_ready;
        logic [3:0]  exp_action;
        logic [1:0]  exp_mindex;
        logic [31:0] exp_din;
    } vec_t;

    vec_t tbl[13];

    initial begin
        logic rdy;
        tbl[0]  = '{1'b1, 2'd0, 32'd5,  4'h0, 1'b1, 4'd4, 2'd0, 32'd5};
        tbl[1]  = '{1'b1, 2'd0, 32'd6,  4'h0, 1'b0, 4'd0, 2'd0, 32'd5};
        tbl[2]  = '{1'b1, 2'd0, 32'd6,  4'h0, 1'b1, 4'd4, 2'd0, 32'd6};
        tbl[3]  = '{1'b0, 2'd0, 32'd6,  4'h0, 1'b0, 4'd0, 2'd0, 32'd6};
        tbl[4]  = '{1'b1, 2'd0, 32'd7,  4'h0, 1'b1, 4'd4, 2'd0, 32'd7};
        tbl[5]  = '{1'b1, 2'd1, 32'd8,  4'h0, 1'b1, 4'd4, 2'd1, 32'd8};
        tbl[6]  = '{1'b1, 2'd0, 32'd9,  4'h0, 1'b1, 4'd4, 2'd0, 32'd9};
        tbl[7]  = '{1'b1, 2'd1, 32'hA,  4'h0, 1'b1, 4'd4, 2'd1, 32'hA};
        tbl[8]  = '{1'b0, 2'd2, 32'd0,  4'h0, 1'b1, 4'd0, 2'd1, 32'hA};
        tbl[9]  = '{1'b1, 2'd1, 32'hB,  4'h2, 1'b0, 4'd0, 2'd1, 32'hA};
        tbl[10] = '{1'b1, 2'd1, 32'hB,  4'h2, 1'b0, 4'd0, 2'd1, 32'hA};
        tbl[11] = '{1'b1, 2'd1, 32'hB,  4'h0, 1'b1, 4'd4, 2'd1, 32'hB};
        tbl[12] = '{1'b0, 2'd1, 32'hB,  4'h0, 1'b0, 4'd0, 2'd1, 32'hB};

        for (int i = 0; i < 32; i++) prog_rom[i] = 16'hA000 + 16'(i);
        for (int i = 0; i < 128; i++) begin
            conf_rom[i] = {4'($urandom), 32'($urandom)};
            if (i % 32 == 3) conf_rom[i][35:32] = 4'd0;
        end

        // Reset state with inputs that would otherwise provoke activity
        n_reset = 1'b0; reload = 1'b1; push_valid = 1'b1; push_machine = 2'd0;
        push_data = 32'hDEAD_BEEF; tx_full = 4'h0;
        model_reset();
        #23;
        chk("reset_outs",
            64'({action, din, index, mindex, loaded, push_ready, prog_addr, conf_addr}), 64'(0));
        @(negedge clk);
        n_reset = 1'b1; reload = 1'b0; push_valid = 1'b0;

        // Abort a load part-way through the config phase with an async reset
        repeat (40) @(posedge clk);
        #3;
        n_reset = 1'b0;
        #1;
        chk("midload_reset",
            64'({action, din, index, mindex, loaded, push_ready, prog_addr, conf_addr}), 64'(0));
        model_reset();
        @(negedge clk);
        n_reset = 1'b1;

        check_load();

        // Directed push sequences
        for (int i = 0; i < 13; i++) begin
            run_cycle(tbl[i].pv, tbl[i].pm, tbl[i].pd, tbl[i].tf, 1'b0, rdy);
            chk($sformatf("tbl_ready[%0d]", i), 64'(rdy), 64'(tbl[i].exp_ready));
            chk($sformatf("tbl_out[%0d]", i), 64'({action, mindex, din}),
                64'({tbl[i].exp_action, tbl[i].exp_mindex, tbl[i].exp_din}));
        end

        // Random pushes against the model
        for (int i = 0; i < 300; i++) begin
            logic [3:0] tf;
            tf = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
            run_cycle(1'($urandom_range(0, 3) != 0), 2'($urandom), $urandom, tf, 1'b0, rdy);
        end

        // Reload wins over a simultaneous push to an idle machine
        run_cycle(1'b0, 2'd3, 32'd0, 4'h0, 1'b0, rdy);
        run_cycle(1'b1, 2'd2, 32'h1234_5678, 4'h0, 1'b1, rdy);
        chk("reload_no_push", 64'({action, loaded}), 64'({4'd0, 1'b0}));
        for (int i = 0; i < 32; i++) prog_rom[i] = 16'($urandom);
        check_load();
        run_cycle(1'b1, 2'd3, 32'hCAFE_0001, 4'h0, 1'b0, rdy);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Bound the run in case the sequencing above ever stalls
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
